// File: rtl/csr_timer_multi.sv
// Multi-channel CSR timer: one prescaled free-running counter plus CHANNELS
// compare channels (one-shot or auto-advancing periodic), each with its own
// pending and enable bits. Sits on the pipeline CSR bus and drives the timer irq.
module csr_timer_multi #(
    parameter logic [11:0] BASE_ADDR   = 12'hBC2,
    parameter int          WIDTH       = 32,
    parameter int          CHANNELS    = 2,
    parameter int          PRESC_WIDTH = 16
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic        read,
    input  logic [2:0]  modify,
    input  logic [31:0] wdata,
    input  logic [11:0] addr,
    output logic [31:0] rdata,
    output logic        valid,
    output logic        irq,
    output logic        AVOID_WARNING
);

    localparam int         NREGS    = 4 + 2 * CHANNELS;
    localparam logic [2:0] OP_WRITE = 3'd1;
    localparam logic [2:0] OP_SET   = 3'd2;
    localparam logic [2:0] OP_CLR   = 3'd3;

    // Read-modify-write of one CSR word; unknown op codes leave it untouched.
    function automatic logic [31:0] f_apply(input logic [31:0] old_val,
                                            input logic [2:0]  op,
                                            input logic [31:0] data);
        case (op)
            OP_WRITE: f_apply = data;
            OP_SET:   f_apply = old_val | data;
            OP_CLR:   f_apply = old_val & ~data;
            default:  f_apply = old_val;
        endcase
    endfunction

    // Architectural state
    logic [WIDTH-1:0]       r_count;
    logic [PRESC_WIDTH-1:0] r_presc;
    logic [PRESC_WIDTH-1:0] r_pcnt;
    logic                   r_run;
    logic [CHANNELS-1:0]    r_ch_en;
    logic [CHANNELS-1:0]    r_periodic;
    logic [CHANNELS-1:0]    r_irq_en;
    logic [CHANNELS-1:0]    r_pend;
    logic [WIDTH-1:0]       r_cmp [CHANNELS];
    logic [WIDTH-1:0]       r_per [CHANNELS];
    logic [31:0]            r_rdata;
    logic                   r_valid;

    // Bus decode and combinational next state
    logic [11:0]            w_off;
    logic                   w_in_range;
    logic                   w_hit;
    logic                   w_mod_op;
    logic [31:0]            w_old;
    logic [31:0]            w_new;
    logic                   w_tick;
    logic [WIDTH-1:0]       w_count_inc;
    logic [CHANNELS-1:0]    w_match;
    logic [CHANNELS-1:0]    w_pend_clr;
    logic [WIDTH-1:0]       w_count_next;
    logic [PRESC_WIDTH-1:0] w_presc_next;
    logic [PRESC_WIDTH-1:0] w_pcnt_next;
    logic                   w_run_next;
    logic [CHANNELS-1:0]    w_ch_en_next;
    logic [CHANNELS-1:0]    w_periodic_next;
    logic [CHANNELS-1:0]    w_irq_en_next;
    logic [CHANNELS-1:0]    w_pend_next;
    logic [WIDTH-1:0]       w_cmp_next [CHANNELS];
    logic [WIDTH-1:0]       w_per_next [CHANNELS];

    assign w_off       = addr - BASE_ADDR;
    assign w_in_range  = (w_off < 12'(NREGS));
    assign w_hit       = w_in_range && (read || (modify != 3'd0));
    assign w_mod_op    = w_in_range &&
                         ((modify == OP_WRITE) || (modify == OP_SET) || (modify == OP_CLR));
    assign w_tick      = r_run && (r_pcnt == r_presc);
    assign w_count_inc = r_count + WIDTH'(1);

    // Per-channel compare: a channel fires on the tick that makes COUNT equal CMP
    genvar gi;
    generate
        for (gi = 0; gi < CHANNELS; gi++) begin : g_match
            assign w_match[gi] = w_tick && r_ch_en[gi] && (w_count_inc == r_cmp[gi]);
        end
    endgenerate

    // Current value of the addressed register, zero-extended to 32 bits
    always_comb begin
        w_old = '0;
        case (w_off)
            12'd0: w_old[WIDTH-1:0] = r_count;
            12'd1: w_old[PRESC_WIDTH-1:0] = r_presc;
            12'd2: begin
                w_old[CHANNELS-1:0]   = r_ch_en;
                w_old[8 +: CHANNELS]  = r_periodic;
                w_old[16 +: CHANNELS] = r_irq_en;
                w_old[31]             = r_run;
            end
            12'd3: w_old[CHANNELS-1:0] = r_pend;
            default: begin
                for (int i = 0; i < CHANNELS; i++) begin
                    if (w_off == 12'(4 + 2 * i)) w_old[WIDTH-1:0] = r_cmp[i];
                    if (w_off == 12'(5 + 2 * i)) w_old[WIDTH-1:0] = r_per[i];
                end
            end
        endcase
    end

    assign w_new = f_apply(w_old, modify, wdata);

    // Counter, prescaler and run: hardware update first, a CSR modify overrides it
    always_comb begin
        w_count_next = w_tick ? w_count_inc : r_count;
        w_pcnt_next  = r_pcnt;
        w_presc_next = r_presc;
        w_run_next   = r_run;
        if (r_run) begin
            w_pcnt_next = w_tick ? '0 : r_pcnt + PRESC_WIDTH'(1);
        end
        if (w_mod_op) begin
            case (w_off)
                12'd0:   w_count_next = w_new[WIDTH-1:0];
                12'd1:   w_presc_next = w_new[PRESC_WIDTH-1:0];
                12'd2:   w_run_next   = w_new[31];
                default: ;
            endcase
        end
    end

    // Channel state: match effects, then CSR overrides; pending set beats clear
    always_comb begin
        w_pend_clr = '0;
        if (w_in_range && (w_off == 12'd3) && ((modify == OP_WRITE) || (modify == OP_CLR))) begin
            w_pend_clr = wdata[CHANNELS-1:0];
        end
        w_pend_next = (r_pend & ~w_pend_clr) | w_match;
        for (int i = 0; i < CHANNELS; i++) begin
            w_cmp_next[i]      = r_cmp[i];
            w_per_next[i]      = r_per[i];
            w_ch_en_next[i]    = r_ch_en[i];
            w_periodic_next[i] = r_periodic[i];
            w_irq_en_next[i]   = r_irq_en[i];
            if (w_match[i]) begin
                if (r_periodic[i]) w_cmp_next[i] = r_cmp[i] + r_per[i];
                else               w_ch_en_next[i] = 1'b0;
            end
            if (w_mod_op) begin
                if (w_off == 12'd2) begin
                    w_ch_en_next[i]    = w_new[i];
                    w_periodic_next[i] = w_new[8 + i];
                    w_irq_en_next[i]   = w_new[16 + i];
                end
                if (w_off == 12'(4 + 2 * i)) w_cmp_next[i] = w_new[WIDTH-1:0];
                if (w_off == 12'(5 + 2 * i)) w_per_next[i] = w_new[WIDTH-1:0];
            end
        end
    end

    // State registers
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_count    <= '0;
            r_presc    <= '0;
            r_pcnt     <= '0;
            r_run      <= 1'b0;
            r_ch_en    <= '0;
            r_periodic <= '0;
            r_irq_en   <= '0;
            r_pend     <= '0;
            for (int i = 0; i < CHANNELS; i++) begin
                r_cmp[i] <= '0;
                r_per[i] <= '0;
            end
        end else begin
            r_count    <= w_count_next;
            r_presc    <= w_presc_next;
            r_pcnt     <= w_pcnt_next;
            r_run      <= w_run_next;
            r_ch_en    <= w_ch_en_next;
            r_periodic <= w_periodic_next;
            r_irq_en   <= w_irq_en_next;
            r_pend     <= w_pend_next;
            for (int i = 0; i < CHANNELS; i++) begin
                r_cmp[i] <= w_cmp_next[i];
                r_per[i] <= w_per_next[i];
            end
        end
    end

    // Bus response: pre-modify value presented the cycle after the request
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_valid <= 1'b0;
            r_rdata <= '0;
        end else begin
            r_valid <= w_hit;
            r_rdata <= w_hit ? w_old : 32'd0;
        end
    end

    assign rdata         = r_rdata;
    assign valid         = r_valid;
    assign irq           = |(r_pend & r_irq_en);
    assign AVOID_WARNING = 1'b0;

endmodule

// File: tb/tb_csr_timer_multi.sv
// Bench for csr_timer_multi: reset/readback vector table, directed timing
// sequences, and a randomized run against a behavioural register model.
module tb_csr_timer_multi;

    localparam logic [11:0] BASE = 12'hBC2;

    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic        read = 1'b0;
    logic [2:0]  modify = 3'd0;
    logic [31:0] wdata = 32'd0;
    logic [11:0] addr = BASE;
    logic [31:0] rdata, rdata8;
    logic        valid, valid8, irq, irq8, aw, aw8;

    int n_checks = 0;
    int n_fail   = 0;

    csr_timer_multi #(.BASE_ADDR(BASE), .WIDTH(32), .CHANNELS(2), .PRESC_WIDTH(16)) dut (
        .clk(clk), .rstn(rstn), .read(read), .modify(modify), .wdata(wdata), .addr(addr),
        .rdata(rdata), .valid(valid), .irq(irq), .AVOID_WARNING(aw));

    csr_timer_multi #(.BASE_ADDR(BASE), .WIDTH(8), .CHANNELS(2), .PRESC_WIDTH(16)) dut8 (
        .clk(clk), .rstn(rstn), .read(read), .modify(modify), .wdata(wdata), .addr(addr),
        .rdata(rdata8), .valid(valid8), .irq(irq8), .AVOID_WARNING(aw8));

    always #5 clk = ~clk;

    // ---------------- behavioural model (32-bit, 2 channels) ----------------
    logic [31:0] m_count, m_cmp [2], m_per [2];
    logic [15:0] m_presc, m_pcnt;
    logic        m_run;
    logic [1:0]  m_en, m_pm, m_ien, m_pend;
    logic [31:0] m_exp_rdata;
    logic        m_exp_valid;

    task automatic model_reset();
        m_count = 0; m_presc = 0; m_pcnt = 0; m_run = 0;
        m_en = 0; m_pm = 0; m_ien = 0; m_pend = 0;
        for (int c = 0; c < 2; c++) begin m_cmp[c] = 0; m_per[c] = 0; end
        m_exp_rdata = 0; m_exp_valid = 0;
    endtask

    function automatic logic [31:0] m_reg(input int off);
        logic [31:0] v;
        v = '0;
        case (off)
            0: v = m_count;
            1: v = {16'h0, m_presc};
            2: begin v[1:0] = m_en; v[9:8] = m_pm; v[17:16] = m_ien; v[31] = m_run; end
            3: v[1:0] = m_pend;
            4, 6: v = m_cmp[(off - 4) / 2];
            5, 7: v = m_per[(off - 5) / 2];
            default: v = '0;
        endcase
        return v;
    endfunction

    task automatic model_step(input logic rd, input logic [2:0] mod, input int off, input logic [31:0] wd);
        logic [31:0] old, nv;
        logic        in_rng, tick;
        logic [1:0]  match;
        in_rng      = (off >= 0) && (off < 8);
        old         = in_rng ? m_reg(off) : 32'd0;
        m_exp_valid = in_rng && (rd || (mod != 3'd0));
        m_exp_rdata = m_exp_valid ? old : 32'd0;
        tick  = m_run && (m_pcnt == m_presc);
        match = 2'b00;
        if (m_run) m_pcnt = tick ? 16'd0 : m_pcnt + 16'd1;
        if (tick) begin
            m_count = m_count + 32'd1;
            for (int c = 0; c < 2; c++) begin
                if (m_en[c] && (m_count == m_cmp[c])) begin
                    match[c] = 1'b1;
                    m_pend[c] = 1'b1;
                    if (m_pm[c]) m_cmp[c] = m_cmp[c] + m_per[c];
                    else         m_en[c] = 1'b0;
                end
            end
        end
        if (in_rng && (mod >= 3'd1) && (mod <= 3'd3)) begin
            if (mod == 3'd1)      nv = wd;
            else if (mod == 3'd2) nv = old | wd;
            else                  nv = old & ~wd;
            case (off)
                0: m_count = nv;
                1: m_presc = nv[15:0];
                2: begin m_en = nv[1:0]; m_pm = nv[9:8]; m_ien = nv[17:16]; m_run = nv[31]; end
                3: if (mod != 3'd2) m_pend = m_pend & ~(wd[1:0] & ~match);
                4, 6: m_cmp[(off - 4) / 2] = nv;
                5, 7: m_per[(off - 5) / 2] = nv;
                default: ;
            endcase
        end
    endtask

    // ---------------- helpers ----------------
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic bus_op(input logic rd, input logic [2:0] mod, input int off, input logic [31:0] wd,
                          output logic [31:0] r_o, output logic v_o);
        @(negedge clk);
        read = rd; modify = mod; wdata = wd; addr = BASE + 12'(off);
        @(posedge clk);
        #1;
        r_o = rdata; v_o = valid;
        read = 1'b0; modify = 3'd0; wdata = 32'd0;
        $display("bus rd=%0d op=%0d off=%0d wdata=%h -> rdata=%h valid=%0d irq=%0d",
                 rd, mod, off, wd, r_o, v_o, irq);
    endtask

    task automatic wr(input int off, input logic [31:0] wd);
        logic [31:0] r; logic v;
        bus_op(1'b0, 3'd1, off, wd, r, v);
    endtask

    task automatic rd_chk(input string name, input int off, input logic [31:0] exp);
        logic [31:0] r; logic v;
        bus_op(1'b1, 3'd0, off, 32'd0, r, v);
        check(name, r, exp);
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic wait_irq(input int max, output int cyc);
        cyc = 0;
        while (!irq && cyc < max) begin
            @(posedge clk); #1;
            cyc++;
        end
    endtask

    task automatic do_reset();
        #2 rstn = 1'b0;
        read = 1'b0; modify = 3'd0; wdata = 32'd0;
        model_reset();
        repeat (2) @(negedge clk);
        rstn = 1'b1;
    endtask

    // ---------------- vector table ----------------
    typedef struct {
        logic        rd;
        logic [2:0]  mod;
        int          off;
        logic [31:0] wd;
        logic [31:0] exp_rd;
        logic        exp_v;
    } vec_t;

    function automatic vec_t mk(input logic rd, input logic [2:0] mod, input int off,
                                input logic [31:0] wd, input logic [31:0] er, input logic ev);
        vec_t v;
        v.rd = rd; v.mod = mod; v.off = off; v.wd = wd; v.exp_rd = er; v.exp_v = ev;
        return v;
    endfunction

    initial begin
        vec_t        vecs [$];
        logic [31:0] r;
        logic        v;
        int          cyc;
        logic        saw;

        for (int i = 0; i < 8; i++) vecs.push_back(mk(1'b1, 3'd0, i, 32'd0, 32'd0, 1'b1));
        vecs.push_back(mk(1'b1, 3'd0, 8,  32'd0,         32'd0,         1'b0));
        vecs.push_back(mk(1'b1, 3'd0, -1, 32'd0,         32'd0,         1'b0));
        vecs.push_back(mk(1'b0, 3'd1, 1,  32'h0000_1234, 32'd0,         1'b1));
        vecs.push_back(mk(1'b1, 3'd0, 1,  32'd0,         32'h0000_1234, 1'b1));
        vecs.push_back(mk(1'b1, 3'd1, 4,  32'hDEAD_BEEF, 32'd0,         1'b1));
        vecs.push_back(mk(1'b1, 3'd2, 4,  32'h0000_0010, 32'hDEAD_BEEF, 1'b1));
        vecs.push_back(mk(1'b1, 3'd3, 4,  32'h0000_000F, 32'hDEAD_BEFF, 1'b1));
        vecs.push_back(mk(1'b1, 3'd0, 4,  32'd0,         32'hDEAD_BEF0, 1'b1));
        vecs.push_back(mk(1'b0, 3'd1, 2,  32'h7FFF_FFFF, 32'd0,         1'b1));
        vecs.push_back(mk(1'b1, 3'd0, 2,  32'd0,         32'h0003_0303, 1'b1));
        vecs.push_back(mk(1'b0, 3'd2, 3,  32'h0000_0003, 32'd0,         1'b1));
        vecs.push_back(mk(1'b1, 3'd0, 3,  32'd0,         32'd0,         1'b1));
        vecs.push_back(mk(1'b0, 3'd4, 7,  32'd5,         32'd0,         1'b1));
        vecs.push_back(mk(1'b1, 3'd0, 7,  32'd0,         32'd0,         1'b1));

        // Reset state
        do_reset();
        #1;
        check("reset_irq", {31'd0, irq}, 32'd0);
        check("reset_valid", {31'd0, valid}, 32'd0);
        check("reset_rdata", rdata, 32'd0);
        check("avoid_warning", {31'd0, aw}, 32'd0);

        // Table: readback, decode range, modify ops, field masking
        for (int i = 0; i < vecs.size(); i++) begin
            bus_op(vecs[i].rd, vecs[i].mod, vecs[i].off, vecs[i].wd, r, v);
            check($sformatf("vec%0d_rdata", i), r, vecs[i].exp_rd);
            check($sformatf("vec%0d_valid", i), {31'd0, v}, {31'd0, vecs[i].exp_v});
        end

        // Prescaler 3: four cycles per count
        do_reset();
        wr(1, 32'd3);
        wr(2, 32'h8000_0000);
        idle(40);
        rd_chk("presc3_count40", 0, 32'd10);

        // Prescaler 0: one count per cycle
        do_reset();
        wr(2, 32'h8000_0000);
        rd_chk("presc0_count_a", 0, 32'd0);
        idle(4);
        rd_chk("presc0_count_b", 0, 32'd5);

        // One-shot on channel 0
        do_reset();
        wr(4, 32'd5);
        wr(2, 32'h8001_0001);
        wait_irq(20, cyc);
        check("oneshot_irq_latency", cyc, 32'd5);
        rd_chk("oneshot_ctrl_en_cleared", 2, 32'h8001_0000);
        rd_chk("oneshot_pend", 3, 32'd1);
        bus_op(1'b0, 3'd3, 3, 32'd1, r, v);
        check("oneshot_irq_after_clear", {31'd0, irq}, 32'd0);
        wr(0, 32'hFFFF_FFF0);
        saw = 1'b0;
        for (int k = 0; k < 30; k++) begin
            @(posedge clk); #1;
            if (irq) saw = 1'b1;
        end
        check("oneshot_no_rematch_after_wrap", {31'd0, saw}, 32'd0);

        // Periodic on channel 1
        do_reset();
        wr(6, 32'd10);
        wr(7, 32'd10);
        wr(2, 32'h8002_0202);
        wait_irq(30, cyc);
        check("periodic_match10", cyc, 32'd10);
        bus_op(1'b0, 3'd3, 3, 32'd2, r, v);
        check("periodic_irq_cleared", {31'd0, irq}, 32'd0);
        wait_irq(30, cyc);
        check("periodic_match20", cyc, 32'd9);
        bus_op(1'b0, 3'd3, 3, 32'd2, r, v);
        wait_irq(30, cyc);
        check("periodic_match30", cyc, 32'd9);
        bus_op(1'b0, 3'd3, 3, 32'd2, r, v);
        rd_chk("periodic_cmp40", 6, 32'd40);
        rd_chk("periodic_ctrl_kept", 2, 32'h8002_0202);

        // Compare advance wraps modulo 2^WIDTH (8-bit instance) vs 32-bit instance
        do_reset();
        wr(0, 32'd249);
        wr(4, 32'd250);
        wr(5, 32'd10);
        wr(2, 32'h8000_0101);
        idle(1);
        bus_op(1'b1, 3'd0, 4, 32'd0, r, v);
        check("w32_cmp_advance", r, 32'd260);
        check("w8_cmp_wrap", rdata8, 32'd4);

        // Clear of pending in the match cycle loses to the set
        do_reset();
        wr(4, 32'd5);
        wr(2, 32'h8001_0001);
        idle(4);
        bus_op(1'b0, 3'd3, 3, 32'd1, r, v);
        check("collide_clear_irq", {31'd0, irq}, 32'd1);
        rd_chk("collide_clear_pend", 3, 32'd1);

        // COUNT written in a tick cycle: CSR value wins, next tick PRESC+1 later
        do_reset();
        wr(1, 32'd3);
        wr(2, 32'h8000_0000);
        idle(3);
        wr(0, 32'd100);
        idle(3);
        rd_chk("collide_count_hold", 0, 32'd100);
        rd_chk("collide_count_next", 0, 32'd101);

        // Asynchronous reset between edges
        do_reset();
        wr(4, 32'd3);
        wr(2, 32'h8001_0001);
        wait_irq(20, cyc);
        check("areset_setup_irq", cyc, 32'd3);
        bus_op(1'b1, 3'd0, 0, 32'd0, r, v);
        check("areset_pre_count", r, 32'd3);
        check("areset_pre_valid", {31'd0, v}, 32'd1);
        #2 rstn = 1'b0;
        #1;
        check("areset_irq", {31'd0, irq}, 32'd0);
        check("areset_valid", {31'd0, valid}, 32'd0);
        check("areset_rdata", rdata, 32'd0);
        @(negedge clk);
        rstn = 1'b1;
        for (int i = 0; i < 8; i++) rd_chk($sformatf("areset_reg%0d", i), i, 32'd0);

        // Randomized traffic against the model
        do_reset();
        for (int c = 0; c < 1500; c++) begin
            logic        t_rd;
            logic [2:0]  t_mod;
            int          t_off;
            logic [31:0] t_wd;
            @(negedge clk);
            t_rd  = ($urandom_range(0, 9) < 7);
            t_mod = ($urandom_range(0, 1) == 0) ? 3'd0 : 3'($urandom_range(1, 7));
            t_off = $urandom_range(0, 9);
            case (t_off)
                0: t_wd = ($urandom_range(0, 7) == 0) ? 32'hFFFF_FFF8 + 32'($urandom_range(0, 7))
                                                      : 32'($urandom_range(0, 40));
                1: t_wd = 32'd0;
                2: t_wd = $urandom | (($urandom_range(0, 3) != 0) ? 32'h8000_0000 : 32'd0);
                4, 6: t_wd = m_count + 32'($urandom_range(1, 12));
                5, 7: t_wd = 32'($urandom_range(0, 8));
                default: t_wd = $urandom;
            endcase
            read = t_rd; modify = t_mod; wdata = t_wd; addr = BASE + 12'(t_off);
            @(posedge clk);
            model_step(t_rd, t_mod, t_off, t_wd);
            #1;
            check("rand_valid", {31'd0, valid}, {31'd0, m_exp_valid});
            check("rand_rdata", rdata, m_exp_rdata);
            check("rand_irq", {31'd0, irq}, {31'd0, |(m_pend & m_ien)});
            if (t_rd || t_mod != 3'd0)
                $display("rand %0d rd=%0d op=%0d off=%0d wdata=%h -> rdata=%h valid=%0d irq=%0d",
                         c, t_rd, t_mod, t_off, t_wd, rdata, valid, irq);
        end
        read = 1'b0; modify = 3'd0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
